// File: rtl/icache_linefill_ctrl_pkg.sv
// Shared constants and types for the icache line-fill sequencer.
// Optional feature macro used by this slice: ICACHE_LINEFILL_BYPASS_EN.
package toy_pack;

    localparam int unsigned MSHR_ENTRY_NUM         = 8;
    localparam int unsigned MSHR_ENTRY_INDEX_WIDTH = $clog2(MSHR_ENTRY_NUM);
    localparam int unsigned ICACHE_INDEX_WIDTH     = 7;
    localparam int unsigned BEAT_NUM               = 4;
    localparam int unsigned BEAT_WIDTH             = 128;
    localparam int unsigned LINE_WIDTH             = BEAT_NUM * BEAT_WIDTH;
    localparam int unsigned BEAT_CNT_WIDTH         = $clog2(BEAT_NUM);

    typedef enum logic [1:0] {
        LF_IDLE  = 2'd0,
        LF_FILL  = 2'd1,
        LF_WRITE = 2'd2,
        LF_DONE  = 2'd3
    } linefill_state_t;

    typedef struct packed {
        logic [MSHR_ENTRY_INDEX_WIDTH-1:0] txnid;
        logic [BEAT_WIDTH-1:0]             data;
        logic                              last;
    } rxdat_pld_t;

endpackage

// File: rtl/icache_linefill_ctrl_if.sv
// Read-data channel, data RAM write port and MSHR retire signals of the line-fill sequencer.
// master = the sequencer side, slave = the surrounding fabric / RAM / MSHR file.
interface icache_linefill_ctrl_if;
    import toy_pack::*;

    logic                              rxdat_vld;
    logic                              rxdat_rdy;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] rxdat_txnid;
    logic [BEAT_WIDTH-1:0]             rxdat_data;
    logic                              rxdat_last;

    logic                              dataram_wr_vld;
    logic                              dataram_wr_rdy;
    logic                              dataram_wr_way;
    logic [ICACHE_INDEX_WIDTH-1:0]     dataram_wr_index;
    logic [LINE_WIDTH-1:0]             dataram_wr_data;

    logic                              linefill_done;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] linefill_ack_index;

    modport master (
        input  rxdat_vld, rxdat_txnid, rxdat_data, rxdat_last, dataram_wr_rdy,
        output rxdat_rdy, dataram_wr_vld, dataram_wr_way, dataram_wr_index,
               dataram_wr_data, linefill_done, linefill_ack_index
    );

    modport slave (
        output rxdat_vld, rxdat_txnid, rxdat_data, rxdat_last, dataram_wr_rdy,
        input  rxdat_rdy, dataram_wr_vld, dataram_wr_way, dataram_wr_index,
               dataram_wr_data, linefill_done, linefill_ack_index
    );

endinterface

// File: rtl/icache_linefill_beat_buf.sv
// Line assembly register: BEAT_NUM slots of BEAT_WIDTH bits, one slot written per enabled cycle.
module icache_linefill_beat_buf
    import toy_pack::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [BEAT_CNT_WIDTH-1:0] wr_slot,
    input  logic [BEAT_WIDTH-1:0]     wr_data,
    output logic [LINE_WIDTH-1:0]     line_data
);

    logic [LINE_WIDTH-1:0] line_d;
    logic [LINE_WIDTH-1:0] line_q;

    // Merge the incoming beat into its slot; other slots keep their contents.
    always_comb begin
        line_d = line_q;
        if (wr_en) begin
            line_d[wr_slot*BEAT_WIDTH +: BEAT_WIDTH] = wr_data;
        end
    end

    // Slot storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_data = line_q;

endmodule

// File: rtl/icache_linefill_ctrl.sv
// Line-fill sequencer: gathers the beats of one refill line, writes the full line into
// the icache data RAM at the MSHR entry's way/index, then pulses the retire to the MSHR file.
// Optional ICACHE_LINEFILL_BYPASS_EN adds a same-cycle mirror of each stored beat.
module icache_linefill_ctrl
    import toy_pack::*;
(
    input  logic                                         clk,
    input  logic                                         rst,
    icache_linefill_ctrl_if.master                       lf,
    input  logic [MSHR_ENTRY_NUM-1:0]                    mshr_rep_way,
    input  logic [MSHR_ENTRY_NUM*ICACHE_INDEX_WIDTH-1:0] mshr_rep_index,
    output logic                                         linefill_err
`ifdef ICACHE_LINEFILL_BYPASS_EN
    ,
    output logic                                         bypass_vld,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0]            bypass_txnid,
    output logic [BEAT_WIDTH-1:0]                        bypass_data
`endif
);

    localparam logic [BEAT_CNT_WIDTH-1:0] CNT_LAST = BEAT_CNT_WIDTH'(BEAT_NUM - 1);
    localparam logic [BEAT_CNT_WIDTH-1:0] CNT_ONE  = BEAT_CNT_WIDTH'(1);

    linefill_state_t                   state_q, state_d;
    logic [BEAT_CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] txnid_q, txnid_d;
    logic                              way_q, way_d;
    logic [ICACHE_INDEX_WIDTH-1:0]     index_q, index_d;
    logic                              rdy_q, rdy_d;
    logic                              err_q, err_d;

    rxdat_pld_t                        pld;
    logic                              beat_fire;
    logic                              buf_wr_en;
    logic [BEAT_CNT_WIDTH-1:0]         buf_wr_slot;
    logic [LINE_WIDTH-1:0]             line_data;

    assign pld       = '{txnid: lf.rxdat_txnid, data: lf.rxdat_data, last: lf.rxdat_last};
    assign beat_fire = lf.rxdat_vld & rdy_q;

    // Next-state, beat storage and error detection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        txnid_d     = txnid_q;
        way_d       = way_q;
        index_d     = index_q;
        err_d       = err_q;
        buf_wr_en   = 1'b0;
        buf_wr_slot = cnt_q;
        case (state_q)
            LF_IDLE: begin
                if (beat_fire) begin
                    buf_wr_en   = 1'b1;
                    buf_wr_slot = '0;
                    txnid_d     = pld.txnid;
                    cnt_d       = CNT_ONE;
                    state_d     = (BEAT_NUM == 1) ? LF_WRITE : LF_FILL;
                end
            end
            LF_FILL: begin
                if (beat_fire) begin
                    if (pld.txnid != txnid_q) begin
                        err_d = 1'b1;
                    end else begin
                        buf_wr_en = 1'b1;
                        cnt_d     = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_d = LF_WRITE;
                            if (!pld.last) begin
                                err_d = 1'b1;
                            end
                        end else if (pld.last) begin
                            err_d   = 1'b1;
                            state_d = LF_WRITE;
                        end
                    end
                end
            end
            LF_WRITE: begin
                if (lf.dataram_wr_rdy) begin
                    state_d = LF_DONE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = LF_IDLE;
            end
        endcase
        // Way/index are captured once on entry to WRITE so the request stays stable while stalled.
        if ((state_q != LF_WRITE) && (state_d == LF_WRITE)) begin
            way_d   = mshr_rep_way[txnid_d];
            index_d = mshr_rep_index[txnid_d*ICACHE_INDEX_WIDTH +: ICACHE_INDEX_WIDTH];
        end
        // Ready is registered from the next state so it reads 0 throughout reset.
        rdy_d = (state_d == LF_IDLE) || (state_d == LF_FILL);
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LF_IDLE;
            cnt_q   <= '0;
            txnid_q <= '0;
            way_q   <= 1'b0;
            index_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txnid_q <= txnid_d;
            way_q   <= way_d;
            index_q <= index_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    icache_linefill_beat_buf u_beat_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (buf_wr_en),
        .wr_slot   (buf_wr_slot),
        .wr_data   (pld.data),
        .line_data (line_data)
    );

    assign lf.rxdat_rdy          = rdy_q;
    assign lf.dataram_wr_vld     = (state_q == LF_WRITE);
    assign lf.dataram_wr_way     = way_q;
    assign lf.dataram_wr_index   = index_q;
    assign lf.dataram_wr_data    = line_data;
    assign lf.linefill_done      = (state_q == LF_DONE);
    assign lf.linefill_ack_index = (state_q == LF_DONE) ? txnid_q : '0;
    assign linefill_err          = err_q;

`ifdef ICACHE_LINEFILL_BYPASS_EN
    assign bypass_vld   = buf_wr_en;
    assign bypass_txnid = pld.txnid;
    assign bypass_data  = pld.data;
`endif

endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// Directed bench for icache_linefill_ctrl; bypass checks active under ICACHE_LINEFILL_BYPASS_EN.
module tb_icache_linefill_ctrl;
    import toy_pack::*;

    localparam logic [127:0] BA = {32{4'hA}};
    localparam logic [127:0] BB = {32{4'hB}};
    localparam logic [127:0] BC = {32{4'hC}};
    localparam logic [127:0] BD = {32{4'hD}};
    localparam logic [127:0] BE = {16{8'h1E}};
    localparam logic [127:0] BF = {16{8'h2F}};
    localparam logic [127:0] BG = {16{8'h36}};
    localparam logic [127:0] BH = {16{8'h48}};
    localparam logic [127:0] BP = {4{32'h0123_4567}};
    localparam logic [127:0] BQ = {4{32'h89AB_CDEF}};
    localparam logic [127:0] BX = {8{16'hDEAD}};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mshr_rep_way;
    logic [55:0] mshr_rep_index;
    logic        linefill_err;
`ifdef ICACHE_LINEFILL_BYPASS_EN
    logic        bypass_vld;
    logic [2:0]  bypass_txnid;
    logic [127:0] bypass_data;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    int unsigned done_cnt = 0;
    int unsigned d0;

    always #5 clk = ~clk;

    icache_linefill_ctrl_if lf ();

    icache_linefill_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .lf             (lf),
        .mshr_rep_way   (mshr_rep_way),
        .mshr_rep_index (mshr_rep_index),
        .linefill_err   (linefill_err)
`ifdef ICACHE_LINEFILL_BYPASS_EN
        ,
        .bypass_vld     (bypass_vld),
        .bypass_txnid   (bypass_txnid),
        .bypass_data    (bypass_data)
`endif
    );

    always @(negedge clk) begin
        if (lf.linefill_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [LINE_WIDTH-1:0] got,
                            input logic [LINE_WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_beat(input logic [2:0] id, input logic [127:0] d, input logic last);
        lf.rxdat_vld   = 1'b1;
        lf.rxdat_txnid = id;
        lf.rxdat_data  = d;
        lf.rxdat_last  = last;
    endtask

    task automatic no_beat();
        lf.rxdat_vld   = 1'b0;
        lf.rxdat_txnid = '0;
        lf.rxdat_data  = '0;
        lf.rxdat_last  = 1'b0;
    endtask

    // Settles the combinational mirror and checks it (expect_vld=0: no beat mirrored).
    task automatic check_bypass(input string tag, input logic expect_vld,
                                input logic [2:0] id, input logic [127:0] d);
        #1;
`ifdef ICACHE_LINEFILL_BYPASS_EN
        check_eq({tag, "_vld"}, bypass_vld, expect_vld);
        if (expect_vld) begin
            check_eq({tag, "_txnid"}, bypass_txnid, id);
            check_eq({tag, "_data"}, bypass_data, d);
        end
`endif
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_rdy"},   lf.rxdat_rdy, 0);
        check_eq({tag, "_wrvld"}, lf.dataram_wr_vld, 0);
        check_eq({tag, "_way"},   lf.dataram_wr_way, 0);
        check_eq({tag, "_index"}, lf.dataram_wr_index, 0);
        check_eq({tag, "_data"},  lf.dataram_wr_data, 0);
        check_eq({tag, "_done"},  lf.linefill_done, 0);
        check_eq({tag, "_ack"},   lf.linefill_ack_index, 0);
        check_eq({tag, "_err"},   linefill_err, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        no_beat();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        no_beat();
        lf.dataram_wr_rdy = 1'b0;
        mshr_rep_way = 8'b0010_0100;
        // Entry i index = i*13+5: entry1=18, entry2=31, entry3=44, entry5=70.
        for (int i = 0; i < 8; i++) mshr_rep_index[i*7 +: 7] = 7'(i * 13 + 5);
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_eq("rdy_after_reset", lf.rxdat_rdy, 1);

        // 1: txnid 5, back-to-back, RAM always ready.
        lf.dataram_wr_rdy = 1'b1;
        d0 = done_cnt;
        put_beat(5, BA, 0); check_bypass("t1_b0", 1, 5, BA); tick();
        check_eq("t1_rdy_fill", lf.rxdat_rdy, 1);
        put_beat(5, BB, 0); check_bypass("t1_b1", 1, 5, BB); tick();
        put_beat(5, BC, 0); check_bypass("t1_b2", 1, 5, BC); tick();
        put_beat(5, BD, 1); check_bypass("t1_b3", 1, 5, BD); tick();
        no_beat();
        check_eq("t1_c4_wrvld", lf.dataram_wr_vld, 1);
        check_eq("t1_c4_rdy",   lf.rxdat_rdy, 0);
        check_eq("t1_c4_way",   lf.dataram_wr_way, 1);
        check_eq("t1_c4_index", lf.dataram_wr_index, 70);
        check_eq("t1_c4_data",  lf.dataram_wr_data, {BD, BC, BB, BA});
        check_eq("t1_c4_done",  lf.linefill_done, 0);
        check_bypass("t1_c4_byp", 0, 0, 0);
        tick();
        check_eq("t1_c5_done",  lf.linefill_done, 1);
        check_eq("t1_c5_ack",   lf.linefill_ack_index, 5);
        check_eq("t1_c5_wrvld", lf.dataram_wr_vld, 0);
        check_eq("t1_c5_rdy",   lf.rxdat_rdy, 0);
        tick();
        check_eq("t1_c6_rdy",   lf.rxdat_rdy, 1);
        check_eq("t1_c6_done",  lf.linefill_done, 0);
        check_eq("t1_err",      linefill_err, 0);
        check_eq("t1_done_cnt", done_cnt - d0, 1);

        // 2: RAM stalls 3 cycles; a stray beat offered during WRITE must be ignored.
        lf.dataram_wr_rdy = 1'b0;
        d0 = done_cnt;
        put_beat(5, BE, 0); tick();
        put_beat(5, BF, 0); tick();
        put_beat(5, BG, 0); tick();
        put_beat(5, BH, 1); tick();
        for (int c = 0; c < 4; c++) begin
            put_beat(5, BX, 0);
            check_eq("t2_wrvld", lf.dataram_wr_vld, 1);
            check_eq("t2_rdy",   lf.rxdat_rdy, 0);
            check_eq("t2_way",   lf.dataram_wr_way, 1);
            check_eq("t2_index", lf.dataram_wr_index, 70);
            check_eq("t2_data",  lf.dataram_wr_data, {BH, BG, BF, BE});
            check_eq("t2_done",  lf.linefill_done, 0);
            check_bypass("t2_byp", 0, 0, 0);
            if (c == 3) lf.dataram_wr_rdy = 1'b1;
            tick();
        end
        no_beat();
        check_eq("t2_done_pulse", lf.linefill_done, 1);
        check_eq("t2_ack",        lf.linefill_ack_index, 5);
        check_eq("t2_rdy_done",   lf.rxdat_rdy, 0);
        tick();
        check_eq("t2_done_clr",   lf.linefill_done, 0);
        check_eq("t2_rdy_idle",   lf.rxdat_rdy, 1);
        check_eq("t2_done_cnt",   done_cnt - d0, 1);

        // 3: foreign txnid in the middle of the line.
        put_beat(5, BA, 0); tick();
        check_eq("t3_err_before", linefill_err, 0);
        put_beat(2, BX, 0); check_bypass("t3_byp_drop", 0, 0, 0); tick();
        check_eq("t3_err_set", linefill_err, 1);
        put_beat(5, BB, 0); tick();
        put_beat(5, BC, 0); tick();
        put_beat(5, BD, 1); tick();
        no_beat();
        check_eq("t3_wrvld", lf.dataram_wr_vld, 1);
        check_eq("t3_index", lf.dataram_wr_index, 70);
        check_eq("t3_data",  lf.dataram_wr_data, {BD, BC, BB, BA});
        tick();
        check_eq("t3_done",  lf.linefill_done, 1);
        check_eq("t3_ack",   lf.linefill_ack_index, 5);
        check_eq("t3_err_sticky", linefill_err, 1);
        tick();

        // 4: early last on beat 1 of txnid 3; slots 2/3 still hold reset zeros.
        do_reset();
        check_eq("t4_err_cleared", linefill_err, 0);
        put_beat(3, BP, 0); tick();
        put_beat(3, BQ, 1); tick();
        no_beat();
        check_eq("t4_wrvld", lf.dataram_wr_vld, 1);
        check_eq("t4_err",   linefill_err, 1);
        check_eq("t4_way",   lf.dataram_wr_way, 0);
        check_eq("t4_index", lf.dataram_wr_index, 44);
        check_eq("t4_data",  lf.dataram_wr_data, {128'h0, 128'h0, BQ, BP});
        tick();
        check_eq("t4_done",  lf.linefill_done, 1);
        check_eq("t4_ack",   lf.linefill_ack_index, 3);
        tick();

        // 5: reset after three beats of txnid 1, then a clean line.
        do_reset();
        d0 = done_cnt;
        put_beat(1, BA, 0); tick();
        put_beat(1, BB, 0); tick();
        put_beat(1, BC, 0); tick();
        rst = 1'b1;
        no_beat();
        #1;
        check_zero("t5_rst");
        tick();
        tick();
        check_eq("t5_no_done", done_cnt - d0, 0);
        rst = 1'b0;
        tick();
        check_eq("t5_rdy", lf.rxdat_rdy, 1);
        put_beat(1, BE, 0); tick();
        put_beat(1, BF, 0); tick();
        put_beat(1, BG, 0); tick();
        put_beat(1, BH, 1); tick();
        no_beat();
        check_eq("t5_wrvld", lf.dataram_wr_vld, 1);
        check_eq("t5_way",   lf.dataram_wr_way, 0);
        check_eq("t5_index", lf.dataram_wr_index, 18);
        check_eq("t5_data",  lf.dataram_wr_data, {BH, BG, BF, BE});
        tick();
        check_eq("t5_done",  lf.linefill_done, 1);
        check_eq("t5_ack",   lf.linefill_ack_index, 1);
        tick();
        check_eq("t5_done_cnt", done_cnt - d0, 1);
        check_eq("t5_err",   linefill_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
